// File: rtl/alu_rr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_pkg
//   Shared definitions for the two-requester ALU scheduler: FSM state
//   encoding, requester ID constants and the round-robin pick function.
//   No ports; imported by alu_rr_scheduler.
// ---------------------------------------------------------------------------
package alu_rr_scheduler_pkg;

  // Scheduler FSM states. The fourth encoding (2'd3) is unused and is
  // steered back to IDLE by the scheduler.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester IDs, as carried on the response bus.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Returns the requester to grant. When both are valid the priority
  // pointer decides; when only one is valid it wins regardless of the
  // pointer. With neither valid the result is don't-care because the
  // ready outputs are also qualified by valid.
  function automatic logic pick_grant(input logic v0,
                                      input logic v1,
                                      input logic prio);
    logic id;
    if (v0 && v1) begin
      id = prio;
    end else if (v1) begin
      id = REQ1;
    end else begin
      id = REQ0;
    end
    return id;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_alu.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_alu
//   Purely combinational add/subtract ALU. cin doubles as the subtract
//   select: when cin=1 operand b is inverted and the carry-in adds the
//   one needed for two's-complement subtraction.
// Ports
//   a, b      in   WIDTH  operands
//   cin       in   1      0 = a+b, 1 = a-b
//   result    out  WIDTH  sum / difference modulo 2^WIDTH
//   carry     out  1      carry out of the adder (for subtract: 1 = no borrow)
//   zero      out  1      result == 0
//   overflow  out  1      signed overflow of the operation
// ---------------------------------------------------------------------------
module alu_rr_scheduler_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // One extra bit on the adder captures the carry out.
  always_comb begin
    b_eff    = cin ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    result   = sum[WIDTH-1:0];
    carry    = sum[WIDTH];
    zero     = (sum[WIDTH-1:0] == '0);
    // Signed overflow: both adder inputs share a sign but the result
    // sign differs from it.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
               (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares a single add/subtract ALU between two requesters with
//   round-robin arbitration and exactly one operation in flight. Each
//   accepted op passes IDLE -> EXEC -> RESP; the result and flags are
//   registered and held on the response bus, tagged with the requester ID,
//   until the consumer takes them.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req0_valid/sub/a/b/ready     requester 0 valid/ready handshake + op
//   req1_valid/sub/a/b/ready     requester 1, same as requester 0
//   rsp_valid, rsp_ready         response handshake
//   rsp_id                       requester that issued the returned op
//   rsp_result/carry/zero/overflow  registered ALU outputs
// ---------------------------------------------------------------------------
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_overflow
);

  state_t           state;
  logic             prio_ptr;

  // Operand registers hold the accepted op steady for the ALU so the
  // requesters are free to change their inputs after the handshake.
  logic             op_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;

  logic             grant_id;
  logic             accept;

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_overflow;

  // Ready is combinational so a requester sees acceptance in the same
  // cycle it presents valid. It is only offered in IDLE and outside reset,
  // and grant_id selects exactly one requester, so both can never be high.
  always_comb begin
    grant_id   = pick_grant(req0_valid, req1_valid, prio_ptr);
    req0_ready = (state == IDLE) && !rst && req0_valid && (grant_id == REQ0);
    req1_ready = (state == IDLE) && !rst && req1_valid && (grant_id == REQ1);
    accept     = req0_ready || req1_ready;
  end

  alu_rr_scheduler_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (op_a),
    .b        (op_b),
    .cin      (op_sub),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // Scheduler FSM. Response fields are captured once in EXEC and then left
  // untouched through RESP, which keeps them stable under back-pressure.
  // A response taken in RESP returns to IDLE without granting, so a new
  // op can only be accepted in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prio_ptr     <= REQ0;
      op_sub       <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= REQ0;
      rsp_valid    <= 1'b0;
      rsp_id       <= REQ0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_sub   <= (grant_id == REQ1) ? req1_sub : req0_sub;
            op_a     <= (grant_id == REQ1) ? req1_a   : req0_a;
            op_b     <= (grant_id == REQ1) ? req1_b   : req0_b;
            op_id    <= grant_id;
            // The pointer always moves to the other requester, even when
            // it was the only one asking.
            prio_ptr <= ~grant_id;
            state    <= EXEC;
          end
        end

        EXEC: begin
          rsp_result   <= alu_result;
          rsp_carry    <= alu_carry;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed bench for alu_rr_scheduler followed by a pseudo-random run
//   against a small arithmetic and round-robin model.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_sub, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_sub, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_overflow;

  int assertCount = 0;
  int failCount   = 0;

  alu_rr_scheduler #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_sub     (req0_sub),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_sub     (req1_sub),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packs {valid, id, result, carry, zero, overflow} for one comparison.
  function automatic logic [31:0] rspVec();
    return {19'd0, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow};
  endfunction

  function automatic logic [31:0] mkRsp(input logic v, input logic id,
                                        input logic [7:0] r, input logic c,
                                        input logic z, input logic o);
    return {19'd0, v, id, r, c, z, o};
  endfunction

  task automatic applyStimulus(input logic which, input logic valid,
                               input logic sub, input logic [7:0] a,
                               input logic [7:0] b);
    if (which) begin
      req1_valid = valid; req1_sub = sub; req1_a = a; req1_b = b;
    end else begin
      req0_valid = valid; req0_sub = sub; req0_a = a; req0_b = b;
    end
  endtask

  // Reference arithmetic using integer math: carry for add is the 9th
  // bit, for subtract it means "no borrow"; overflow is the signed result
  // leaving the 8-bit range.
  function automatic logic [31:0] modelRsp(input logic id, input logic sub,
                                           input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] r;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      ur = ua + ub; sr = sa + sb; c = (ur > 255);
    end
    r = 8'(ur);
    o = (sr > 127) || (sr < -128);
    return mkRsp(1'b1, id, r, c, (r == 8'd0), o);
  endfunction

  logic       pend0, pend1, sub0, sub1, modelPrio, busy, gid, expGrant, expValid;
  logic [7:0] a0, b0, a1, b1;
  logic [31:0] expVec;
  int opsDone, cycles;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held two cycles; ready stays low during reset even with valid.
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
    #1;
    checkOutput("ready0_in_reset", req0_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    checkOutput("reset_rsp", rspVec(), 32'd0);
    checkOutput("reset_ready", {req0_ready, req1_ready}, 2'b00);

    // Single add from requester 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 8'h03);
    #1;
    checkOutput("add_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA, 8'h55);
    checkOutput("add_exec_novalid", rsp_valid, 1'b0);
    tick();
    checkOutput("add_rsp", rspVec(), mkRsp(1, 0, 8'h08, 0, 0, 0));
    rsp_ready = 1'b1;
    tick();
    checkOutput("add_rsp_drop", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // Fresh reset, then both requesters at once: requester 0 goes first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 8'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h7F, 8'h01);
    #1;
    checkOutput("both_ready", {req0_ready, req1_ready}, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("exec_no_ready1", req1_ready, 1'b0);
    tick();
    checkOutput("sub_zero_rsp", rspVec(), mkRsp(1, 0, 8'h00, 1, 1, 0));
    checkOutput("resp_no_ready1", req1_ready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    checkOutput("idle_ready1", {req0_ready, req1_ready}, 2'b01);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("ovf_rsp", rspVec(), mkRsp(1, 1, 8'h80, 0, 0, 1));
    tick();
    rsp_ready = 1'b0;
    checkOutput("ovf_rsp_drop", rsp_valid, 1'b0);

    // Back-pressure: response held for five cycles, no grants meanwhile.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01);
    #1;
    checkOutput("bp_ready1", {req0_ready, req1_ready}, 2'b01);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'h01);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_hold_rsp", rspVec(), mkRsp(1, 1, 8'h00, 1, 1, 0));
      checkOutput("bp_hold_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checkOutput("bp_released", rsp_valid, 1'b0);
    checkOutput("bp_after_ready0", {req0_ready, req1_ready}, 2'b10);

    // Reset while requester 0's op is in EXEC: it must vanish.
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    checkOutput("midop_reset_rsp", rspVec(), 32'd0);
    tick();
    checkOutput("midop_no_rsp_1", rsp_valid, 1'b0);
    tick();
    checkOutput("midop_no_rsp_2", rsp_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, 8'h04);
    #1;
    checkOutput("post_reset_prio0", {req0_ready, req1_ready}, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("post_reset_rsp0", rspVec(), mkRsp(1, 0, 8'h03, 0, 0, 0));
    tick();
    #1;
    checkOutput("post_reset_ready1", {req0_ready, req1_ready}, 2'b01);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("post_reset_rsp1", rspVec(), mkRsp(1, 1, 8'h07, 0, 0, 0));
    tick();
    rsp_ready = 1'b0;

    // Random traffic: each requester keeps its op valid until accepted.
    modelPrio = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0; expValid = 1'b0; expVec = 32'd0;
    sub0 = 1'b0; sub1 = 1'b0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    opsDone = 0; cycles = 0;
    while (opsDone < 2000 && cycles < 40000) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1'b1; sub0 = 1'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1'b1; sub1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      end
      applyStimulus(1'b0, pend0, sub0, a0, b0);
      applyStimulus(1'b1, pend1, sub1, a1, b1);
      rsp_ready = 1'($urandom);
      #1;
      busy = expValid;
      if (req0_ready || req1_ready) begin
        checkOutput("rnd_ready_onehot", {req0_ready & req1_ready}, 1'b0);
        checkOutput("rnd_grant_when_idle", busy, 1'b0);
        gid = req1_ready;
        expGrant = (pend0 && pend1) ? modelPrio : (pend0 ? 1'b0 : 1'b1);
        checkOutput("rnd_rr_grant", gid, expGrant);
        modelPrio = ~gid;
        if (gid) begin
          expVec = modelRsp(1'b1, sub1, a1, b1);
          pend1 = 1'b0;
        end else begin
          expVec = modelRsp(1'b0, sub0, a0, b0);
          pend0 = 1'b0;
        end
        expValid = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        checkOutput("rnd_rsp_expected", busy, 1'b1);
        checkOutput("rnd_rsp", rspVec(), expVec);
        expValid = 1'b0;
        opsDone++;
      end
      tick();
      cycles++;
    end
    checkOutput("rnd_ops_completed", (opsDone >= 2000), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
